// File: rtl/zeroriscy_wb_pkg.sv
// Shared types and helpers for the zeroriscy write-back arbiter.
//   wb_entry_t  : buffered PPU result (destination + data)
//   addr_width(): register index width, 4 for RV32E, else 5
package zeroriscy_wb_pkg;

  localparam int WB_DATA_WIDTH = 32;

  typedef struct packed {
    logic [4:0]               waddr;
    logic [WB_DATA_WIDTH-1:0] wdata;
  } wb_entry_t;

  function automatic int addr_width(input bit rv32e);
    return rv32e ? 4 : 5;
  endfunction

endpackage

// File: rtl/zeroriscy_wb_arbiter_if.sv
// Bus bundle between the core/PPU side and the write-back arbiter.
//   slave  : arbiter view (takes ALU/PPU/decoder requests, drives write port,
//            ppu_ready_o and hazard_o)
//   master : core/PPU/decoder view
interface zeroriscy_wb_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  alu_we_i;
  logic [4:0]            alu_waddr_i;
  logic [DATA_WIDTH-1:0] alu_wdata_i;
  logic                  issue_i;
  logic [4:0]            issue_waddr_i;
  logic                  ppu_valid_i;
  logic                  ppu_ready_o;
  logic [4:0]            ppu_waddr_i;
  logic [DATA_WIDTH-1:0] ppu_wdata_i;
  logic [4:0]            raddr_a_i;
  logic [4:0]            raddr_b_i;
  logic [4:0]            raddr_c_i;
  logic                  hazard_o;
  logic [4:0]            waddr_a_o;
  logic [DATA_WIDTH-1:0] wdata_a_o;
  logic                  we_a_o;

  modport slave (
    input  alu_we_i, alu_waddr_i, alu_wdata_i, issue_i, issue_waddr_i,
           ppu_valid_i, ppu_waddr_i, ppu_wdata_i, raddr_a_i, raddr_b_i, raddr_c_i,
    output ppu_ready_o, hazard_o, waddr_a_o, wdata_a_o, we_a_o
  );

  modport master (
    output alu_we_i, alu_waddr_i, alu_wdata_i, issue_i, issue_waddr_i,
           ppu_valid_i, ppu_waddr_i, ppu_wdata_i, raddr_a_i, raddr_b_i, raddr_c_i,
    input  ppu_ready_o, hazard_o, waddr_a_o, wdata_a_o, we_a_o
  );
endinterface

// File: rtl/zeroriscy_wb_fifo.sv
// Synchronous FIFO of wb_entry_t holding PPU results awaiting the write port.
//   clk_int, rst_n : clock, async active-low reset (pointers/count only)
//   push, din      : enqueue (ignored when full)
//   pop            : dequeue head (ignored when empty)
//   head           : oldest entry, valid when !empty
//   full/empty/count : occupancy
module zeroriscy_wb_fifo
  import zeroriscy_wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_int,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        din,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk_int) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/zeroriscy_wb_arbiter.sv
// Write-back arbiter owning the register file write port.
//   clk_int, rst_n : clock, async active-low reset
//   bus (slave)    : ALU result (always accepted), PPU valid/ready result,
//                    PPU issue + decoder read addresses (hazard_o),
//                    register file write port (waddr_a_o/wdata_a_o/we_a_o)
// Priority: ALU write, then FIFO head, then (optional) direct PPU bypass.
// Optional feature: define ZERORISCY_WB_BYPASS_EN to let a PPU result go
// straight to the write port when the FIFO is empty and the ALU is idle.
module zeroriscy_wb_arbiter
  import zeroriscy_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RV32E      = 0,
  parameter int FIFO_DEPTH = 2
) (
  input logic                   clk_int,
  input logic                   rst_n,
  zeroriscy_wb_arbiter_if.slave bus
);

  localparam int ADDR_WIDTH = addr_width(RV32E != 0);
  localparam int NUM_REGS   = 1 << ADDR_WIDTH;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef logic [ADDR_WIDTH-1:0] idx_t;

  function automatic idx_t reg_idx(input logic [4:0] a);
    return a[ADDR_WIDTH-1:0];
  endfunction

  wb_entry_t             fifo_din, fifo_head;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  ppu_ready, bypass_take, sel_valid;
  idx_t                  sel_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS-1:0]   pending, set_mask, clr_mask;

  // A pop in the same cycle never frees a slot: ready looks at count only.
`ifdef ZERORISCY_WB_BYPASS_EN
  assign ppu_ready = (fifo_count != CNT_W'(FIFO_DEPTH)) | (fifo_empty & ~bus.alu_we_i);
`else
  assign ppu_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
`endif

  assign fifo_push = bus.ppu_valid_i & ppu_ready & ~fifo_full & ~bypass_take;
  assign fifo_din  = '{waddr: bus.ppu_waddr_i, wdata: WB_DATA_WIDTH'(bus.ppu_wdata_i)};

  zeroriscy_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_int (clk_int),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    sel_valid   = 1'b0;
    sel_idx     = '0;
    sel_data    = '0;
    fifo_pop    = 1'b0;
    bypass_take = 1'b0;
    if (bus.alu_we_i) begin
      sel_valid = 1'b1;
      sel_idx   = reg_idx(bus.alu_waddr_i);
      sel_data  = bus.alu_wdata_i;
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      sel_idx   = reg_idx(fifo_head.waddr);
      sel_data  = DATA_WIDTH'(fifo_head.wdata);
      fifo_pop  = 1'b1;
    end
`ifdef ZERORISCY_WB_BYPASS_EN
    else if (bus.ppu_valid_i) begin
      sel_valid   = 1'b1;
      sel_idx     = reg_idx(bus.ppu_waddr_i);
      sel_data    = bus.ppu_wdata_i;
      bypass_take = 1'b1;
    end
`endif
  end

  // Writes are suppressed for x0 and while reset is asserted.
  assign bus.we_a_o      = rst_n & sel_valid & (sel_idx != '0);
  assign bus.waddr_a_o   = rst_n ? 5'(sel_idx) : 5'd0;
  assign bus.wdata_a_o   = rst_n ? sel_data : '0;
  assign bus.ppu_ready_o = ppu_ready;

  // Set wins over clear on the same register; bit 0 is never set.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.issue_i && reg_idx(bus.issue_waddr_i) != '0)
      set_mask[reg_idx(bus.issue_waddr_i)] = 1'b1;
    if ((fifo_pop || bypass_take) && sel_idx != '0)
      clr_mask[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_mask) | set_mask;
  end

  assign bus.hazard_o = pending[reg_idx(bus.raddr_a_i)] |
                        pending[reg_idx(bus.raddr_b_i)] |
                        pending[reg_idx(bus.raddr_c_i)] |
                        (bus.issue_i & pending[reg_idx(bus.issue_waddr_i)]);

endmodule

// File: doc/zeroriscy_wb_arbiter.md
# zeroriscy_wb_arbiter

Write-back arbiter that owns the single write port (waddr/wdata/we) of the core register file. It merges always-accepted single-cycle ALU/LSU results with valid/ready results from the multi-cycle PPU coprocessor, and buffers PPU results in a small FIFO. It also keeps a per-register pending scoreboard so the decoder can stall on any of its three read addresses.

## Interface
- DATA_WIDTH, 32, result/register width
- RV32E, 0, 1 = 16 registers (4-bit index, bit 4 ignored), 0 = 32 registers
- FIFO_DEPTH, 2, PPU result buffer entries (≥1)

- clk_int  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alu_we_i  in  1  core result write request (no backpressure)
- alu_waddr_i  in  5  core destination register
- alu_wdata_i  in  DATA_WIDTH  core result
- issue_i  in  1  PPU op issued this cycle; marks destination pending
- issue_waddr_i  in  5  PPU op destination register
- ppu_valid_i  in  1  PPU result valid
- ppu_ready_o  out  1  arbiter can accept a PPU result
- ppu_waddr_i  in  5  PPU result destination
- ppu_wdata_i  in  DATA_WIDTH  PPU result
- raddr_a_i, raddr_b_i, raddr_c_i  in  5 each  decoder source registers
- hazard_o  out  1  a source or issue_waddr_i register is pending
- waddr_a_o  out  5  register file write address
- wdata_a_o  out  DATA_WIDTH  register file write data
- we_a_o  out  1  register file write enable

## Operation
- Register index = low ADDR_WIDTH bits (4 if RV32E, else 5). Upper bit is ignored everywhere.
- Write port priority:
  - alu_we_i=1: drive the ALU address/data with we_a_o=1.
  - Otherwise, FIFO non-empty: drive the FIFO head, we_a_o=1, and pop it.
  - Otherwise: we_a_o=0.
- The ALU is never stalled. The FIFO drains only in cycles with no ALU write.
- PPU handshake: a transfer occurs when ppu_valid_i & ppu_ready_o. The result is pushed onto the FIFO tail.
- ppu_ready_o = FIFO not full. It is combinational from the occupancy count. A pop in the same cycle does not free the slot for that cycle.
- PPU must hold waddr/wdata stable while valid is high and not ready.
- Destination x0:
  - we_a_o is forced to 0 whenever the driven address is 0.
  - An x0 FIFO entry still pops and consumes its slot.
  - issue_i to x0 sets no pending bit.
- Scoreboard: one pending bit per register 1..NUM_REGS-1.
  - Set on issue_i.
  - Cleared when a FIFO-sourced write with that address pops.
  - If a set and a clear hit the same register in one cycle, set wins.
- hazard_o = pending[raddr_a] | pending[raddr_b] | pending[raddr_c] | (issue_i & pending[issue_waddr_i]). Combinational.
- The decoder must not issue while hazard_o=1. The ALU must not write a pending register; this is guaranteed by the decoder and not checked here.

## Timing
- ALU path: 0 cycles, combinational to the write port.
- PPU path: accepted in cycle N, earliest write in cycle N+1. Further delayed one cycle per ALU write.
- Pending bit clears on the clk_int edge at the end of the draining cycle. hazard_o drops the following cycle.
- Reset values: FIFO empty, scoreboard all 0, we_a_o=0, waddr_a_o=0, wdata_a_o=0, hazard_o=0, ppu_ready_o=1.
- Reset mid-operation discards buffered results and pending bits. No write is emitted.
- Full FIFO with continuous ALU writes: ppu_ready_o stays 0 and the PPU stalls indefinitely. This is legal.

## Configuration
- ZERORISCY_WB_BYPASS_EN defined:
  - A PPU result that arrives with the FIFO empty and alu_we_i=0 goes straight to the write port in the same cycle. It is not enqueued, and its pending bit clears at that edge.
  - ppu_ready_o is 1 in that case even if FIFO_DEPTH entries were reported full that cycle.
- Undefined: every PPU result passes through the FIFO. Minimum latency is 1 cycle.

## Structure
- Package zeroriscy_wb_pkg:
  - wb_entry_t struct {waddr[4:0], wdata[DATA_WIDTH-1:0]}.
  - ADDR_WIDTH function of RV32E.
- Sub-module zeroriscy_wb_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/count.
- Scoreboard, hazard compare and write-port mux live in the top level.

## Test plan
- Reset, then PPU result x5=0x1234 with the ALU idle → ppu_ready_o=1; cycle N+1: we_a_o=1, waddr_a_o=5, wdata_a_o=0x1234 (bypass build: cycle N).
- issue_i x7; raddr_b_i=7 → hazard_o=1 until the x7 PPU result writes, 0 the cycle after.
- ALU writes x3 on 4 consecutive cycles while the PPU delivers x8 and x9 (FIFO_DEPTH=2) → ppu_ready_o=0 on the third result; x8 then x9 written in the 2 cycles after the ALU stops.
- PPU result to x0, and issue_i to x0 → we_a_o never 1, no pending bit, the FIFO slot is freed.
- issue_i x10 in the same cycle the FIFO pops x10 → x10 stays pending, hazard_o=1 for raddr_c_i=10.
- rst_n low with 2 entries buffered → we_a_o=0, FIFO empty, hazard_o=0; no write after release.
